// File: rtl/conv_sa3x3_stream.sv
// ---------------------------------------------------------------------------
// conv_sa3x3_stream
//   3x3 convolution controller around one sa3x3 weight-stationary array and
//   two fadd8 adders. It slides a 3x3 window over an IMG_H x IMG_W map with a
//   configurable STRIDE, applies an optional ReLU, and streams each result out
//   through a valid/ready port that supports backpressure.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             begin a run; only honoured in IDLE
//   relu_en           captured with an accepted start; 1 = clamp negatives to 0
//   w_flat            kernel, element (r,c) at [(r*3+c)*8 +: 8]
//   img_flat          input map, element (r,c) at [(r*IMG_W+c)*8 +: 8]
//   out_valid/ready   result handshake
//   out_data          8-bit result (mod 256)
//   out_row/out_col   output coordinates of out_data
//   busy              high whenever the controller is not in IDLE
//   done              one-cycle pulse at the end of a run
//
// Also contains the fadd8 and sa3x3 leaf modules.
// ---------------------------------------------------------------------------

// 8-bit wrap-around adder.
module fadd8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] s
);
    assign s = a + b;
endmodule

// ---------------------------------------------------------------------------
// sa3x3: 3x3 weight-stationary array.
//   weight_load shifts one kernel row in at the top, so the bottom kernel row
//   must be loaded first. Every PE in column m sees act_in(m+1). Partial sums
//   travel down the column through registers: row 2 first, then row 1. Row 0
//   is added combinationally, so the activation sequence row r+2, r+1, r
//   yields the finished column sum in the same cycle as the last activation.
//   Column m is fed m cycles after column 0. Each column output therefore
//   passes through (2-m) deskew registers, and all three column sums line up
//   in the same cycle. clear flushes those deskew registers.
// Ports: clk, rst_n, clear, weight_load, w_in1..3 (kernel row, col 0..2),
//        act_in1..3, psum_in1..3, psum_out1..3 (one per column).
// ---------------------------------------------------------------------------
module sa3x3 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       weight_load,
    input  logic [7:0] w_in1,
    input  logic [7:0] w_in2,
    input  logic [7:0] w_in3,
    input  logic [7:0] act_in1,
    input  logic [7:0] act_in2,
    input  logic [7:0] act_in3,
    input  logic [7:0] psum_in1,
    input  logic [7:0] psum_in2,
    input  logic [7:0] psum_in3,
    output logic [7:0] psum_out1,
    output logic [7:0] psum_out2,
    output logic [7:0] psum_out3
);
    logic [2:0][2:0][7:0] wgt;      // [pe row][column]
    logic [2:0][7:0]      w_in, act, psum_in, col_out, psum_out;

    assign w_in    = {w_in3, w_in2, w_in1};
    assign act     = {act_in3, act_in2, act_in1};
    assign psum_in = {psum_in3, psum_in2, psum_in1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wgt <= '0;
        end else if (weight_load) begin
            wgt[0] <= w_in;
            wgt[1] <= wgt[0];
            wgt[2] <= wgt[1];
        end
    end

    genvar m;
    generate
        for (m = 0; m < 3; m++) begin : g_col
            logic [7:0] ps2, ps1;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ps2 <= '0;
                    ps1 <= '0;
                end else begin
                    ps2 <= psum_in[m] + wgt[2][m] * act[m];
                    ps1 <= ps2 + wgt[1][m] * act[m];
                end
            end

            assign col_out[m] = ps1 + wgt[0][m] * act[m];

            if (m == 2) begin : g_nodly
                assign psum_out[m] = col_out[m];
            end else begin : g_dly
                localparam int D = 2 - m;
                logic [D-1:0][7:0] dly;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        dly <= '0;
                    end else if (clear) begin
                        dly <= '0;
                    end else begin
                        dly[0] <= col_out[m];
                        for (int k = 1; k < D; k++) dly[k] <= dly[k-1];
                    end
                end

                assign psum_out[m] = dly[D-1];
            end
        end
    endgenerate

    assign psum_out1 = psum_out[0];
    assign psum_out2 = psum_out[1];
    assign psum_out3 = psum_out[2];
endmodule

// ---------------------------------------------------------------------------
// Top level controller.
// ---------------------------------------------------------------------------
module conv_sa3x3_stream #(
    parameter int IMG_H  = 4,
    parameter int IMG_W  = 4,
    parameter int STRIDE = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          relu_en,
    input  logic [71:0]                   w_flat,
    input  logic [IMG_H*IMG_W*8-1:0]      img_flat,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [7:0]                    out_data,
    output logic [$clog2((IMG_H-3)/STRIDE+1):0] out_row,
    output logic [$clog2((IMG_W-3)/STRIDE+1):0] out_col,
    output logic                          busy,
    output logic                          done
);
    localparam int OH = (IMG_H-3)/STRIDE + 1;
    localparam int OW = (IMG_W-3)/STRIDE + 1;
    localparam int RW = $clog2(OH) + 1;
    localparam int CW = $clog2(OW) + 1;
    localparam int PW = $clog2(IMG_H*IMG_W*8);

    typedef enum logic [3:0] {
        IDLE, WLOAD1, WLOAD2, WLOAD3,
        FEED1, FEED2, FEED3, FEED4, FEED5,
        STALL, DRAIN, DONE
    } state_t;

    state_t          state, next;
    logic [RW-1:0]   i_cnt;
    logic [CW-1:0]   j_cnt;
    logic            relu_q, first_win;
    logic            clear, weight_load, feeding;
    logic [2:0]      feed_idx;
    logic [23:0]     wrow_bits;
    logic [2:0][7:0] acts;
    logic [7:0]      ps1, ps2, ps3, s01, sum, res;
    logic            last_win, slot_free;

    // Second result register. A window can finish while the output slot still
    // holds an unaccepted result. The new result waits here, and the controller
    // stalls until the consumer takes the slot.
    logic            held_v;
    logic [7:0]      held_data;
    logic [RW-1:0]   held_row;
    logic [CW-1:0]   held_col;

    int              r_base, c_base, t, pix;
    logic [PW-1:0]   bidx;

    assign last_win  = (i_cnt == RW'(OH-1)) && (j_cnt == CW'(OW-1));
    assign slot_free = !out_valid || out_ready;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign r_base    = int'(i_cnt) * STRIDE;
    assign c_base    = int'(j_cnt) * STRIDE;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    // Next state and array controls
    always_comb begin
        next        = state;
        clear       = 1'b0;
        weight_load = 1'b0;
        feeding     = 1'b0;
        feed_idx    = 3'd0;
        wrow_bits   = '0;
        case (state)
            IDLE: begin
                clear = 1'b1;
                if (start) next = WLOAD1;
            end
            WLOAD1: begin
                weight_load = 1'b1;
                wrow_bits   = w_flat[48 +: 24];
                next        = WLOAD2;
            end
            WLOAD2: begin
                weight_load = 1'b1;
                wrow_bits   = w_flat[24 +: 24];
                next        = WLOAD3;
            end
            WLOAD3: begin
                weight_load = 1'b1;
                wrow_bits   = w_flat[0 +: 24];
                next        = FEED1;
            end
            FEED1: begin
                feeding  = 1'b1;
                feed_idx = 3'd0;
                clear    = !first_win;
                next     = FEED2;
            end
            FEED2: begin
                feeding  = 1'b1;
                feed_idx = 3'd1;
                next     = FEED3;
            end
            FEED3: begin
                feeding  = 1'b1;
                feed_idx = 3'd2;
                next     = FEED4;
            end
            FEED4: begin
                feeding  = 1'b1;
                feed_idx = 3'd3;
                next     = FEED5;
            end
            FEED5: begin
                feeding  = 1'b1;
                feed_idx = 3'd4;
                if (last_win)       next = DRAIN;
                else if (slot_free) next = FEED1;
                else                next = STALL;
            end
            STALL: begin
                clear = 1'b1;
                if (out_ready) next = FEED1;
            end
            DRAIN: begin
                if (!out_valid || (out_ready && !held_v)) next = DONE;
            end
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Skewed activation feed. Column m runs m cycles behind column 0 and sees
    // window rows bottom-up: r+2, r+1, r.
    always_comb begin
        acts = '0;
        t    = 0;
        pix  = 0;
        bidx = '0;
        if (feeding) begin
            for (int m = 0; m < 3; m++) begin
                t = int'(feed_idx) - m;
                if (t >= 0 && t <= 2) begin
                    pix     = (r_base + 2 - t) * IMG_W + c_base + m;
                    bidx    = PW'(pix * 8);
                    acts[m] = img_flat[bidx +: 8];
                end
            end
        end
    end

    sa3x3 u_sa (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .weight_load(weight_load),
        .w_in1      (wrow_bits[7:0]),
        .w_in2      (wrow_bits[15:8]),
        .w_in3      (wrow_bits[23:16]),
        .act_in1    (acts[0]),
        .act_in2    (acts[1]),
        .act_in3    (acts[2]),
        .psum_in1   (8'd0),
        .psum_in2   (8'd0),
        .psum_in3   (8'd0),
        .psum_out1  (ps1),
        .psum_out2  (ps2),
        .psum_out3  (ps3)
    );

    fadd8 u_add0 (.a(ps1), .b(ps2), .s(s01));
    fadd8 u_add1 (.a(s01), .b(ps3), .s(sum));

    assign res = (relu_q && sum[7]) ? 8'd0 : sum;

    // Window counters and per-run flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_cnt     <= '0;
            j_cnt     <= '0;
            relu_q    <= 1'b0;
            first_win <= 1'b0;
        end else if (state == IDLE && start) begin
            i_cnt     <= '0;
            j_cnt     <= '0;
            relu_q    <= relu_en;
            first_win <= 1'b1;
        end else if (state == FEED5) begin
            first_win <= 1'b0;
            if (!last_win) begin
                if (j_cnt == CW'(OW-1)) begin
                    j_cnt <= '0;
                    i_cnt <= i_cnt + 1'b1;
                end else begin
                    j_cnt <= j_cnt + 1'b1;
                end
            end
        end
    end

    // Output slot and hold register. When a load and a handshake happen on the
    // same edge, the load wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            held_v    <= 1'b0;
            held_data <= '0;
            held_row  <= '0;
            held_col  <= '0;
        end else if (state == FEED5) begin
            if (slot_free) begin
                out_valid <= 1'b1;
                out_data  <= res;
                out_row   <= i_cnt;
                out_col   <= j_cnt;
            end else begin
                held_v    <= 1'b1;
                held_data <= res;
                held_row  <= i_cnt;
                held_col  <= j_cnt;
            end
        end else if (out_valid && out_ready) begin
            if (held_v) begin
                out_data <= held_data;
                out_row  <= held_row;
                out_col  <= held_col;
                held_v   <= 1'b0;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_conv_sa3x3_stream.sv
// Scoreboard bench for conv_sa3x3_stream: a 4x4/stride-1 instance (A) and a
// 5x5/stride-2 instance (B). Stimulus pushes hand-computed results into a
// queue per instance; monitors pop and compare on every handshake.
module tb_conv_sa3x3_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic         start_a, relu_a, ready_a;
    logic [71:0]  w_a;
    logic [127:0] img_a;
    logic         vld_a, busy_a, done_a;
    logic [7:0]   data_a;
    logic [1:0]   row_a, col_a;

    logic         start_b, relu_b, ready_b;
    logic [71:0]  w_b;
    logic [199:0] img_b;
    logic         vld_b, busy_b, done_b;
    logic [7:0]   data_b;
    logic [1:0]   row_b, col_b;

    conv_sa3x3_stream #(.IMG_H(4), .IMG_W(4), .STRIDE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .relu_en(relu_a),
        .w_flat(w_a), .img_flat(img_a), .out_valid(vld_a), .out_ready(ready_a),
        .out_data(data_a), .out_row(row_a), .out_col(col_a),
        .busy(busy_a), .done(done_a)
    );

    conv_sa3x3_stream #(.IMG_H(5), .IMG_W(5), .STRIDE(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .relu_en(relu_b),
        .w_flat(w_b), .img_flat(img_b), .out_valid(vld_b), .out_ready(ready_b),
        .out_data(data_b), .out_row(row_b), .out_col(col_b),
        .busy(busy_b), .done(done_b)
    );

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] r;
        logic [1:0] c;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   hs_a[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_cnt_a = 0;
    int   done_cnt_b = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done_a) done_cnt_a <= done_cnt_a + 1;
    always @(negedge clk) if (done_b) done_cnt_b <= done_cnt_b + 1;

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // Monitors
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && vld_a && ready_a) begin
            if (q_a.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL a_extra: got data %0d at (%0d,%0d), expected no result",
                         data_a, row_a, col_a);
            end else begin
                e = q_a.pop_front();
                chk("a_data", data_a, e.d);
                chk("a_row", row_a, e.r);
                chk("a_col", col_a, e.c);
                hs_a.push_back(cyc);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && vld_b && ready_b) begin
            if (q_b.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL b_extra: got data %0d, expected no result", data_b);
            end else begin
                e = q_b.pop_front();
                chk("b_data", data_b, e.d);
                chk("b_row", row_b, e.r);
                chk("b_col", col_b, e.c);
            end
        end
    end

    task automatic push4_a(input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3);
        q_a.push_back({d0, 2'd0, 2'd0});
        q_a.push_back({d1, 2'd0, 2'd1});
        q_a.push_back({d2, 2'd1, 2'd0});
        q_a.push_back({d3, 2'd1, 2'd1});
    endtask

    task automatic seq_img_a();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                img_a[(r*4+c)*8 +: 8] = 8'(r*4 + c + 1);
        for (int k = 0; k < 9; k++) w_a[k*8 +: 8] = 8'h01;
    endtask

    task automatic wait_idle_a(input int budget);
        int n = 0;
        while (busy_a && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("a_idle", busy_a, 0);
    endtask

    // One run on instance A. bp > 0 holds out_ready low that many cycles
    // after the first valid; out_data must hold hold_val meanwhile.
    task automatic run_a(input logic relu, input bit meas, input int bp, input int hold_val);
        int n = 0;
        int bad = 0;
        @(posedge clk); #1;
        start_a = 1'b1;
        relu_a  = relu;
        @(posedge clk); #1;
        start_a = 1'b0;
        relu_a  = 1'b0;
        while (!vld_a && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (meas) chk("first_valid_latency", n, 8);
        if (bp > 0) begin
            ready_a = 1'b0;
            repeat (bp) begin
                @(posedge clk); #1;
                if (!(vld_a && data_a == 8'(hold_val) && busy_a)) bad++;
            end
            chk("bp_hold", bad, 0);
            ready_a = 1'b1;
        end
        wait_idle_a(300);
    endtask

    task automatic test1_check(input string tag);
        int d0 = done_cnt_a;
        hs_a.delete();
        push4_a(8'd54, 8'd63, 8'd90, 8'd99);
        run_a(1'b0, 1'b1, 0, 0);
        @(posedge clk); #1;
        chk({tag, "_done_pulses"}, done_cnt_a - d0, 1);
        chk({tag, "_queue_empty"}, q_a.size(), 0);
        chk({tag, "_handshakes"}, hs_a.size(), 4);
        if (hs_a.size() == 4)
            for (int k = 1; k < 4; k++) chk({tag, "_spacing"}, hs_a[k] - hs_a[k-1], 5);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0;
        rst_n = 1'b0;
        start_a = 1'b0; relu_a = 1'b0; ready_a = 1'b1;
        start_b = 1'b0; relu_b = 1'b0; ready_b = 1'b1;
        seq_img_a();
        img_b = '0;
        w_b   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", vld_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_data", data_a, 0);
        chk("rst_row", row_a, 0);
        chk("rst_col", col_a, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Test 1: basic 4x4 stride 1
        test1_check("t1");

        // Test 2: 5x5 stride 2, centre-only kernel
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                img_b[(r*5+c)*8 +: 8] = 8'(r*5 + c + 1);
        w_b = '0;
        w_b[(1*3+1)*8 +: 8] = 8'h01;
        q_b.push_back({8'd7,  2'd0, 2'd0});
        q_b.push_back({8'd9,  2'd0, 2'd1});
        q_b.push_back({8'd17, 2'd1, 2'd0});
        q_b.push_back({8'd19, 2'd1, 2'd1});
        d0 = done_cnt_b;
        @(posedge clk); #1;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        begin
            int n = 0;
            while ((busy_b || q_b.size() != 0) && n < 300) begin
                @(posedge clk); #1;
                n++;
            end
        end
        chk("t2_idle", busy_b, 0);
        chk("t2_done_pulses", done_cnt_b - d0, 1);
        chk("t2_queue_empty", q_b.size(), 0);

        // Test 3: backpressure after the first result
        d0 = done_cnt_a;
        push4_a(8'd54, 8'd63, 8'd90, 8'd99);
        run_a(1'b0, 1'b0, 12, 54);
        @(posedge clk); #1;
        chk("t3_done_pulses", done_cnt_a - d0, 1);
        chk("t3_queue_empty", q_a.size(), 0);

        // Test 4: ReLU with all weights -1 on an all-ones image
        for (int k = 0; k < 9; k++) w_a[k*8 +: 8] = 8'hFF;
        for (int k = 0; k < 16; k++) img_a[k*8 +: 8] = 8'h01;
        push4_a(8'hF7, 8'hF7, 8'hF7, 8'hF7);
        run_a(1'b0, 1'b0, 0, 0);
        chk("t4_norelu_queue_empty", q_a.size(), 0);
        push4_a(8'h00, 8'h00, 8'h00, 8'h00);
        run_a(1'b1, 1'b0, 0, 0);
        chk("t4_relu_queue_empty", q_a.size(), 0);

        // Test 5: reset during window (0,1) FEED3
        seq_img_a();
        q_a.push_back({8'd54, 2'd0, 2'd0});
        @(posedge clk); #1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_abort_valid", vld_a, 0);
        chk("t5_abort_busy", busy_a, 0);
        chk("t5_first_seen", q_a.size(), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test1_check("t5");

        // Test 6: start pulses while busy are ignored
        d0 = done_cnt_a;
        push4_a(8'd54, 8'd63, 8'd90, 8'd99);
        @(posedge clk); #1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        wait_idle_a(300);
        repeat (20) @(posedge clk);
        #1;
        chk("t6_stays_idle", busy_a, 0);
        chk("t6_done_pulses", done_cnt_a - d0, 1);
        chk("t6_queue_empty", q_a.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/conv_sa3x3_stream.md
Name: conv_sa3x3_stream

Overview:
Parametrised 3x3 convolution controller driving one sa3x3 weight-stationary array plus two fadd8 adders. It generalises fixed 4x4-input / 2x2-output convolution to an IMG_H x IMG_W input with configurable stride and optional ReLU. Results stream out through a valid/ready port with backpressure instead of fixed output registers. It sits between the image/weight buffers and the downstream pooling/writeback stage.

Parameters:
IMG_H, 4, input map rows, >=3
IMG_W, 4, input map columns, >=3
STRIDE, 1, window step in rows and columns, 1 or 2
OH, (IMG_H-3)/STRIDE+1, output rows (derived, localparam)
OW, (IMG_W-3)/STRIDE+1, output cols (derived, localparam)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin convolution; honoured only in IDLE
relu_en  in  1  sampled on accepted start; 1 = clamp negative results to 0
w_flat  in  72  kernel; element (r,c) at bits [(r*3+c)*8 +: 8]
img_flat  in  IMG_H*IMG_W*8  input map; element (r,c) at bits [(r*IMG_W+c)*8 +: 8]
out_valid  out  1  out_data/out_row/out_col hold a result
out_ready  in  1  consumer accepts the result this cycle
out_data  out  8  convolution result
out_row  out  clog2(OH)+1  output row index
out_col  out  clog2(OW)+1  output column index
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse, run complete

Behaviour:
- Reset (async, rst_n=0): state IDLE; out_valid, out_data, out_row, out_col, done = 0; window counters = 0; relu flag = 0. Reset mid-run aborts the run and drops any pending result.
- w_flat and img_flat must be stable from the accepted start until done. They are not captured.
- States: IDLE -> WLOAD1 -> WLOAD2 -> WLOAD3 -> FEED1..FEED5 -> (next window: FEED1 or STALL) / (last window: DRAIN) -> DONE -> IDLE.
- IDLE: sa3x3 clear=1, all acts 0. start=1 moves to WLOAD1 and latches relu_en.
- WLOAD1/2/3: weight_load=1, with w_in1..3 = kernel row 2, then row 1, then row 0 (bottom row first).
- Window at output (i,j) uses r=i*STRIDE, c=j*STRIDE. In FEEDk (k=1..5), act_in for column m (m=0..2) = img(r+2-(k-1-m), c+m) when 0<=k-1-m<=2, otherwise 0.
- psum_in1..3 are always 0.
- FEED1 asserts clear=1 for every window except the first of a run.
- FEED5: sum = psum_out1+psum_out2+psum_out3, computed mod 256 via fadd8. If relu flag is set and sum[7]=1, the result is 0.
  - The result loads the output slot at the clock edge ending FEED5: out_valid<=1, and out_row/out_col <= i/j.
- Output slot: a handshake occurs when out_valid && out_ready, and clears out_valid unless a new result loads on the same edge (the load wins). Data is held stable while out_valid && !out_ready.
- Window order is raster: j increments, and on wrap to 0, i increments.
- After FEED5 with windows remaining: enter FEED1 if (!out_valid || out_ready) this cycle, else STALL.
  - STALL: clear=1, acts 0; exit to FEED1 when out_ready=1.
  - With out_ready held high there are zero stall cycles, giving one result per 5 cycles.
- After the last FEED5: DRAIN waits until the final result is handshaken, then DONE (done=1 for one cycle, busy=1), then IDLE.
- start asserted outside IDLE is ignored.
- Latency: first out_valid rises 8 cycles after the start-accept edge (3 load + 5 feed). The total for a 4x4 input with ready high is 3+4*5 feed cycles, plus drain and DONE.

Test Plan:
1. IMG 4x4, STRIDE 1, img(r,c)=r*4+c+1, all weights 1, out_ready=1 -> results 54 (0,0), 63 (0,1), 90 (1,0), 99 (1,1), in that order, 5 cycles apart; first valid 8 cycles after start; done pulses once after the last handshake.
2. IMG 5x5, STRIDE 2, img(r,c)=r*5+c+1, centre weight 1 and all others 0 -> outputs 7, 9, 17, 19 at (0,0), (0,1), (1,0), (1,1).
3. Backpressure: test 1 with out_ready low for 12 cycles after the first valid -> out_data holds 54 and the controller sits in STALL. It resumes when out_ready rises; all four values are correct, with none lost or duplicated.
4. ReLU: all weights 8'hFF, image all 1 -> out_data 8'hF7 with relu_en=0; 8'h00 with relu_en=1.
5. Reset mid-run: drop rst_n during window (0,1) FEED3 -> out_valid=0 and busy=0 immediately. A new start then produces the correct full sequence from test 1.
6. start pulsed while busy -> ignored; exactly four results and one done pulse.
